// File: rtl/iso7816_t0_tpdu_engine_if.sv
// Host-side bundle of the T=0 TPDU engine: command header, host data streams and completion status.
// The host drives through the master modport; the engine attaches through the slave modport.
interface iso7816_t0_tpdu_engine_if;
   logic       start;
   logic [7:0] cla;
   logic [7:0] ins;
   logic [7:0] p1;
   logic [7:0] p2;
   logic [7:0] p3;
   logic       isWrite;
   logic [7:0] hostTxData;
   logic       hostTxValid;
   logic       hostTxReady;
   logic [7:0] hostRxData;
   logic       hostRxValid;
   logic       busy;
   logic       done;
   logic [7:0] sw1;
   logic [7:0] sw2;
   logic [2:0] errorCode;

   modport master (
      output start, cla, ins, p1, p2, p3, isWrite, hostTxData, hostTxValid,
      input  hostTxReady, hostRxData, hostRxValid, busy, done, sw1, sw2, errorCode
   );

   modport slave (
      input  start, cla, ins, p1, p2, p3, isWrite, hostTxData, hostTxValid,
      output hostTxReady, hostRxData, hostRxValid, busy, done, sw1, sw2, errorCode
   );
endinterface

// File: rtl/iso7816_t0_tpdu_engine.sv
// T=0 TPDU sequencer: sends the 5-byte header to the master UART, decodes procedure bytes,
// moves P3 data bytes between host and card, and returns SW1/SW2 or an error code.
module iso7816_t0_tpdu_engine #(
   parameter logic [23:0] WAIT_TIMEOUT_CLKS = 24'd4000000
) (
   input  logic                            clk,
   input  logic                            reset,
   iso7816_t0_tpdu_engine_if.slave         host,
   output logic [7:0]                      dataIn_o,
   output logic                            nWeDataIn_o,
   input  logic [7:0]                      dataOut_i,
   output logic                            nCsDataOut_o,
   input  logic [7:0]                      statusOut_i,
   output logic                            nCsStatusOut_o
);
   typedef enum logic [2:0] {
      S_IDLE, S_SEND_HDR, S_WAIT_PROC, S_XFER_ALL, S_XFER_ONE, S_WAIT_SW2, S_DONE, S_ERROR
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  hdr_q [0:4];
   logic [7:0]  hdr_in [0:4];
   logic        is_write_q;
   logic [2:0]  idx_q, idx_d;
   logic [8:0]  rem_q, rem_d;
   logic        wrote_q, rd_blk_q;
   logic [23:0] tmo_q, tmo_d;
   logic [7:0]  sw1_q, sw1_d, sw2_q, sw2_d;
   logic [2:0]  err_q, err_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        load_hdr, nwe, ncs, tx_ready;
   logic [7:0]  data_in, hdr_byte;
   logic        tx_pending, line_err, buf_full, can_write, active, rx_state, rd_go;

   assign tx_pending = statusOut_i[6];
   assign line_err   = statusOut_i[2] | statusOut_i[1];
   assign buf_full   = statusOut_i[0];
   // statusOut lags a write by one cycle, so never write in back-to-back cycles
   assign can_write  = !tx_pending && !wrote_q;
   assign active     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
   assign rx_state   = (state_q == S_WAIT_PROC) || (state_q == S_WAIT_SW2) ||
                       (((state_q == S_XFER_ALL) || (state_q == S_XFER_ONE)) && !is_write_q);
   assign rd_go      = rx_state && buf_full && !rd_blk_q;

   assign hdr_in[0] = host.cla;
   assign hdr_in[1] = host.ins;
   assign hdr_in[2] = host.p1;
   assign hdr_in[3] = host.p2;
   assign hdr_in[4] = host.p3;

   always_comb begin
      hdr_byte = hdr_q[0];
      case (idx_q)
         3'd1:    hdr_byte = hdr_q[1];
         3'd2:    hdr_byte = hdr_q[2];
         3'd3:    hdr_byte = hdr_q[3];
         3'd4:    hdr_byte = hdr_q[4];
         default: hdr_byte = hdr_q[0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rem_d      = rem_q;
      tmo_d      = rx_state ? tmo_q + 24'd1 : 24'd0;
      sw1_d      = sw1_q;
      sw2_d      = sw2_q;
      err_d      = err_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      load_hdr   = 1'b0;
      nwe        = 1'b1;
      ncs        = 1'b1;
      data_in    = 8'h00;
      tx_ready   = 1'b0;
      if (rd_go) begin
         ncs   = 1'b0;
         tmo_d = 24'd0;
      end
      case (state_q)
         S_IDLE: begin
            if (host.start) begin
               load_hdr = 1'b1;
               idx_d    = 3'd0;
               rem_d    = (host.p3 == 8'h00 && !host.isWrite) ? 9'd256 : {1'b0, host.p3};
               sw1_d    = 8'h00;
               sw2_d    = 8'h00;
               err_d    = 3'd0;
               state_d  = S_SEND_HDR;
            end
         end
         S_SEND_HDR: begin
            if (can_write) begin
               nwe     = 1'b0;
               data_in = hdr_byte;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd4) state_d = S_WAIT_PROC;
            end
         end
         S_WAIT_PROC: begin
            if (rd_go) begin
               if (dataOut_i == 8'h60) begin
                  state_d = S_WAIT_PROC;
               end else if (dataOut_i == hdr_q[1]) begin
                  if (rem_q != 9'd0) state_d = S_XFER_ALL;
               end else if (dataOut_i == ~hdr_q[1]) begin
                  if (rem_q != 9'd0) state_d = S_XFER_ONE;
               end else if (dataOut_i[7:4] == 4'h6 || dataOut_i[7:4] == 4'h9) begin
                  sw1_d   = dataOut_i;
                  state_d = S_WAIT_SW2;
               end else begin
                  err_d   = 3'd1;
                  state_d = S_ERROR;
               end
            end
         end
         S_XFER_ALL, S_XFER_ONE: begin
            if (is_write_q) begin
               tx_ready = can_write;
               if (host.hostTxValid && can_write) begin
                  nwe     = 1'b0;
                  data_in = host.hostTxData;
               end
            end else if (rd_go) begin
               rx_valid_d = 1'b1;
               rx_data_d  = dataOut_i;
            end
            if (!nwe || rx_valid_d) begin
               rem_d = (rem_q != 9'd0) ? rem_q - 9'd1 : 9'd0;
               if (rem_q <= 9'd1 || state_q == S_XFER_ONE) state_d = S_WAIT_PROC;
            end
         end
         S_WAIT_SW2: begin
            if (rd_go) begin
               sw2_d   = dataOut_i;
               state_d = S_DONE;
            end
         end
         S_DONE, S_ERROR: state_d = S_IDLE;
         default:         state_d = S_IDLE;
      endcase
      if (rx_state && !rd_go && (tmo_q + 24'd1 == WAIT_TIMEOUT_CLKS)) begin
         err_d   = 3'd2;
         state_d = S_ERROR;
      end
      // line errors win over anything else happening in the same cycle
      if (active && line_err) begin
         err_d      = 3'd3;
         state_d    = S_ERROR;
         nwe        = 1'b1;
         ncs        = 1'b1;
         data_in    = 8'h00;
         tx_ready   = 1'b0;
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         is_write_q <= 1'b0;
         idx_q      <= 3'd0;
         rem_q      <= 9'd0;
         wrote_q    <= 1'b0;
         rd_blk_q   <= 1'b0;
         tmo_q      <= 24'd0;
         sw1_q      <= 8'h00;
         sw2_q      <= 8'h00;
         err_q      <= 3'd0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         if (load_hdr) is_write_q <= host.isWrite;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         wrote_q    <= !nwe;
         rd_blk_q   <= !ncs;
         tmo_q      <= tmo_d;
         sw1_q      <= sw1_d;
         sw2_q      <= sw2_d;
         err_q      <= err_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_hdr
         always_ff @(posedge clk) begin
            if (reset)         hdr_q[gi] <= 8'h00;
            else if (load_hdr) hdr_q[gi] <= hdr_in[gi];
         end
      end
   endgenerate

   assign dataIn_o         = data_in;
   assign nWeDataIn_o      = nwe;
   assign nCsDataOut_o     = ncs;
   assign nCsStatusOut_o   = 1'b0;
   assign host.hostTxReady = tx_ready;
   assign host.hostRxData  = rx_data_q;
   assign host.hostRxValid = rx_valid_q;
   assign host.busy        = active;
   assign host.done        = (state_q == S_DONE) || (state_q == S_ERROR);
   assign host.sw1         = sw1_q;
   assign host.sw2         = sw2_q;
   assign host.errorCode   = err_q;
endmodule
